// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

    localparam int SUB_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit subtractor cell: d = a - b - bin, bout set when the bit borrows.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, reusing a single subtractor cell and a borrow flop.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start_i; results from the last operation held
//   RUN   | one operand bit per clock, WIDTH cycles
//   DONE  | one-cycle done_o pulse; results were loaded on entry
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] Diff_o,
    output logic             Borrow_o,
    output logic             Zero_o
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] diff_sr;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             bout_bit;
    logic [WIDTH-1:0] diff_full;
    logic             last_bit;

    full_subtractor_bit u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // The bit computed this cycle lands in the MSB; after the last bit this is the full result.
    assign diff_full = {d_bit, diff_sr};
    assign last_bit  = (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand/result shift registers, borrow flop, bit counter and result registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            diff_sr  <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
            Diff_o   <= '0;
            Borrow_o <= 1'b0;
            Zero_o   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_sr     <= A_i;
                        b_sr     <= B_i;
                        diff_sr  <= '0;
                        borrow_q <= 1'b0;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    diff_sr  <= diff_full[WIDTH-1:1];
                    borrow_q <= bout_bit;
                    if (last_bit) begin
                        cnt      <= '0;
                        Diff_o   <= diff_full;
                        Borrow_o <= bout_bit;
                        Zero_o   <= (diff_full == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a scoreboard of expected results.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             zero;
    } exp_t;

    logic             clk_i   = 1'b0;
    logic             rst_n   = 1'b1;
    logic             start_i = 1'b0;
    logic [WIDTH-1:0] A_i     = '0;
    logic [WIDTH-1:0] B_i     = '0;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] Diff_o;
    logic             Borrow_o;
    logic             Zero_o;

    int               n_checks  = 0;
    int               n_fail    = 0;
    int               cyc       = 0;
    logic [WIDTH-1:0] last_diff = '0;
    exp_t             sb[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .A_i      (A_i),
        .B_i      (B_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .Diff_o   (Diff_o),
        .Borrow_o (Borrow_o),
        .Zero_o   (Zero_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.diff   = a - b;
        e.borrow = (a < b);
        e.zero   = (e.diff == '0);
        sb.push_back(e);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_diff"},   32'(Diff_o),   32'(e.diff));
            check({tag, "_borrow"}, 32'(Borrow_o), 32'(e.borrow));
            check({tag, "_zero"},   32'(Zero_o),   32'(e.zero));
            last_diff = e.diff;
        end
    endtask

    // Start one operation and follow it to done; inject > 0 pulses a second
    // start (A=FF, B=00) in that RUN cycle, which must be ignored.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int inject);
        int   lat;
        int   busy_cnt;
        logic hold_ok;
        lat      = 0;
        busy_cnt = 0;
        hold_ok  = 1'b1;
        A_i      = a;
        B_i      = b;
        start_i  = 1'b1;
        push_exp(a, b);
        do begin
            step();
            lat++;
            if (lat == 1) start_i = 1'b0;
            if (inject > 0 && lat == inject) begin
                A_i     = 8'hFF;
                B_i     = 8'h00;
                start_i = 1'b1;
            end
            if (inject > 0 && lat == inject + 1) start_i = 1'b0;
            if (!done_o) begin
                if (busy_o) busy_cnt++;
                if (Diff_o !== last_diff) hold_ok = 1'b0;
            end
        end while (!done_o && lat < 20);
        check({tag, "_done_seen"}, 32'(done_o), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        check({tag, "_no_partial"}, 32'(hold_ok), 32'd1);
        check({tag, "_busy_in_done"}, 32'(busy_o), 32'd0);
        check_result(tag);
        step();
        check({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        int               extra_done;
        int               extra_busy;
        int               lat;
        int               prev;
        logic             hold_ok;
        logic [WIDTH-1:0] bta [3];
        logic [WIDTH-1:0] btb [3];

        bta = '{8'h33, 8'h01, 8'hC8};
        btb = '{8'h11, 8'h02, 8'hC8};

        #2 rst_n = 1'b0;
        step();
        step();
        check("rst_busy",   32'(busy_o),   32'd0);
        check("rst_done",   32'(done_o),   32'd0);
        check("rst_diff",   32'(Diff_o),   32'd0);
        check("rst_borrow", 32'(Borrow_o), 32'd0);
        check("rst_zero",   32'(Zero_o),   32'd1);
        rst_n = 1'b1;
        step();

        do_op("basic",  8'h5A, 8'h3C, 0);
        do_op("borrow", 8'h3C, 8'h5A, 0);
        do_op("wrap",   8'h00, 8'h01, 0);
        do_op("zero",   8'hA5, 8'hA5, 0);

        do_op("busy_start", 8'h10, 8'h01, 3);
        extra_done = 0;
        extra_busy = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done_o) extra_done++;
            if (busy_o) extra_busy++;
        end
        check("busy_start_no_second_done", 32'(extra_done), 32'd0);
        check("busy_start_no_second_run",  32'(extra_busy), 32'd0);
        check("busy_start_diff_held",      32'(Diff_o),     32'h0F);

        A_i     = 8'h80;
        B_i     = 8'h01;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        step();
        check("midrst_busy_before", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   32'(busy_o),   32'd0);
        check("midrst_done",   32'(done_o),   32'd0);
        check("midrst_diff",   32'(Diff_o),   32'd0);
        check("midrst_borrow", 32'(Borrow_o), 32'd0);
        check("midrst_zero",   32'(Zero_o),   32'd1);
        extra_done = 0;
        step();
        if (done_o) extra_done++;
        step();
        if (done_o) extra_done++;
        rst_n     = 1'b1;
        last_diff = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done_o) extra_done++;
        end
        check("midrst_no_done", 32'(extra_done), 32'd0);
        do_op("after_rst", 8'h80, 8'h01, 0);

        prev    = 0;
        A_i     = bta[0];
        B_i     = btb[0];
        push_exp(bta[0], btb[0]);
        start_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hold_ok = 1'b1;
            lat     = 0;
            do begin
                step();
                lat++;
                if (!done_o && Diff_o !== last_diff) hold_ok = 1'b0;
            end while (!done_o && lat < 30);
            check("b2b_done_seen", 32'(done_o), 32'd1);
            check("b2b_stable",    32'(hold_ok), 32'd1);
            if (i > 0) check("b2b_spacing", 32'(cyc - prev), 32'(WIDTH + 2));
            prev = cyc;
            check_result("b2b");
            if (i < 2) begin
                A_i = bta[i + 1];
                B_i = btb[i + 1];
                push_exp(bta[i + 1], btb[i + 1]);
            end else begin
                start_i = 1'b0;
            end
        end
        extra_busy = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (busy_o) extra_busy++;
        end
        check("b2b_stops", 32'(extra_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
